// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, ready-handshake memory read, instruction register.
// Define FETCH_TIMEOUT_EN to build the wait-cycle timeout with a sticky FAULT flag.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_WIDTH     = 26,
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET      = 26'h0001000,
    parameter int unsigned          TIMEOUT_CYCLES = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FETCH_REQ,
    input  logic                  PC_LOAD,
    input  logic [ADDR_WIDTH-1:0] PC_NEXT,
    input  logic                  MEM_READY,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    output logic                  MEM_READ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PC_INC,
    output logic                  IR_VALID,
    output logic                  BUSY,
    output logic                  FAULT
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]   instr_d;
    logic                    mem_read_d;
    logic                    ir_valid_d;
    logic                    busy_d;
    logic                    pend_valid;
    logic                    pend_valid_d;
    logic [ADDR_WIDTH-1:0]   pend_pc;
    logic [ADDR_WIDTH-1:0]   pend_pc_d;
    logic                    fault_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic       fault_d;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_d;
`else
    assign fault_q = 1'b0;
`endif

    assign PC_INC = ADDR_WIDTH'(PC + 1'b1);
    assign FAULT  = fault_q;

    // State and output registers; reset also discards any in-flight fetch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            PC          <= PC_RESET;
            INSTRUCTION <= '0;
            MEM_ADDR    <= '0;
            MEM_READ    <= 1'b0;
            IR_VALID    <= 1'b0;
            BUSY        <= 1'b0;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
`ifdef FETCH_TIMEOUT_EN
            fault_q     <= 1'b0;
            wait_cnt    <= 8'd0;
`endif
        end else begin
            state       <= state_d;
            PC          <= pc_d;
            INSTRUCTION <= instr_d;
            MEM_ADDR    <= mem_addr_d;
            MEM_READ    <= mem_read_d;
            IR_VALID    <= ir_valid_d;
            BUSY        <= busy_d;
            pend_valid  <= pend_valid_d;
            pend_pc     <= pend_pc_d;
`ifdef FETCH_TIMEOUT_EN
            fault_q     <= fault_d;
            wait_cnt    <= wait_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        pc_d         = PC;
        mem_addr_d   = MEM_ADDR;
        instr_d      = INSTRUCTION;
        mem_read_d   = MEM_READ;
        ir_valid_d   = IR_VALID;
        busy_d       = BUSY;
        pend_valid_d = pend_valid;
        pend_pc_d    = pend_pc;
`ifdef FETCH_TIMEOUT_EN
        fault_d      = fault_q;
        wait_cnt_d   = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (PC_LOAD) begin
                    pc_d = PC_NEXT;
                end
                if (FETCH_REQ && !fault_q) begin
                    mem_addr_d   = PC_LOAD ? PC_NEXT : PC;
                    mem_read_d   = 1'b1;
                    busy_d       = 1'b1;
                    ir_valid_d   = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = REQ;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d   = 8'd0;
`endif
                end
            end
            REQ: begin
                if (MEM_READY) begin
                    instr_d      = MEM_DATA;
                    ir_valid_d   = 1'b1;
                    mem_read_d   = 1'b0;
                    busy_d       = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = IDLE;
                    // A load on the completion edge beats a pending target, which beats increment.
                    if (PC_LOAD) begin
                        pc_d = PC_NEXT;
                    end else if (pend_valid) begin
                        pc_d = pend_pc;
                    end else begin
                        pc_d = ADDR_WIDTH'(MEM_ADDR + 1'b1);
                    end
                end else begin
                    if (PC_LOAD) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = PC_NEXT;
                    end
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d = 8'(wait_cnt + 8'd1);
                    if (wait_cnt == TIMEOUT_LAST) begin
                        mem_read_d   = 1'b0;
                        busy_d       = 1'b0;
                        fault_d      = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = IDLE;
                        if (PC_LOAD) begin
                            pc_d = PC_NEXT;
                        end else if (pend_valid) begin
                            pc_d = pend_pc;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the multi-cycle processor: owns the program counter, issues instruction reads to memory with a ready handshake, and holds the fetched word in an instruction register. It feeds the control unit (INSTRUCTION, IR_VALID) and the datapath (PC, PC_INC). The control unit's fetch state pulses FETCH_REQ, and the write-back state returns branch/jump targets through PC_LOAD/PC_NEXT.

## Interface
- ADDR_WIDTH, 26: PC / memory word-address width.
- DATA_WIDTH, 32: instruction width.
- PC_RESET, 26'h0001000: PC value after reset.
- TIMEOUT_CYCLES, 15: max wait cycles for MEM_READY (timeout build only); legal 1..255.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- FETCH_REQ  in  1  start a fetch at the current PC (single-cycle pulse).
- PC_LOAD  in  1  load PC_NEXT into PC.
- PC_NEXT  in  ADDR_WIDTH  branch/jump target.
- MEM_READY  in  1  memory has valid MEM_DATA this cycle.
- MEM_DATA  in  DATA_WIDTH  instruction word from memory.
- MEM_READ  out  1  read request, held until handshake completes.
- MEM_ADDR  out  ADDR_WIDTH  fetch address, stable while MEM_READ=1.
- INSTRUCTION  out  DATA_WIDTH  instruction register.
- PC  out  ADDR_WIDTH  current PC.
- PC_INC  out  ADDR_WIDTH  PC+1, combinational from PC.
- IR_VALID  out  1  INSTRUCTION holds a freshly fetched word.
- BUSY  out  1  fetch in progress (state REQ).
- FAULT  out  1  sticky fetch timeout (timeout build only).

## Operation
- States: IDLE, REQ. Reset values: state IDLE, PC=PC_RESET, INSTRUCTION=0, MEM_ADDR=0, MEM_READ=0, IR_VALID=0, BUSY=0, FAULT=0, pending-load flag=0, wait counter=0.
- IDLE, FETCH_REQ=1: MEM_ADDR <= (PC_LOAD ? PC_NEXT : PC); MEM_READ <= 1; BUSY <= 1; IR_VALID <= 0; go to REQ. If PC_LOAD=1 in the same cycle, PC <= PC_NEXT as well.
- IDLE, PC_LOAD=1 only: PC <= PC_NEXT. IR_VALID is unchanged.
- REQ, MEM_READY=1: INSTRUCTION <= MEM_DATA; IR_VALID <= 1; MEM_READ <= 0; BUSY <= 0; go to IDLE. PC update on this edge:
  - PC <= pending target, if a load is pending (pending flag cleared);
  - otherwise PC <= MEM_ADDR+1.
- REQ, MEM_READY=0: hold MEM_READ and MEM_ADDR.
- FETCH_REQ while in REQ: ignored (no queueing).
- PC_LOAD while in REQ: capture PC_NEXT into the pending register; it is applied at completion. A later PC_LOAD in the same REQ overwrites the earlier one. PC_LOAD on the completion edge itself has priority over the increment.
- Arithmetic: PC+1 is modulo 2^ADDR_WIDTH; PC=all-ones wraps to 0 with no flag.
- MEM_READY while in IDLE: ignored. INSTRUCTION holds its value until the next completed fetch.
- RST low at any time, including mid-REQ: immediate return to reset values. MEM_READ drops asynchronously, and the in-flight fetch is discarded.

## Timing
- All outputs are registered, except PC_INC, which is combinational from PC.
- Minimum latency: FETCH_REQ sampled at edge N → MEM_READ=1 after N. If MEM_READY=1 at edge N+1 → IR_VALID=1, INSTRUCTION and PC updated after N+1.
- Each wait cycle (MEM_READY=0) adds exactly one cycle.
- Back-to-back: a FETCH_REQ sampled on the edge after completion starts the next fetch immediately. Throughput is one instruction per 2 cycles at zero wait.
- MEM_DATA is sampled only on the edge where state=REQ and MEM_READY=1.

## Configuration
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to REQ and increments on each REQ edge with MEM_READY=0.
  - When the count reaches TIMEOUT_CYCLES with MEM_READY still 0, the fetch aborts: MEM_READ <= 0, BUSY <= 0, FAULT <= 1 (sticky until RST), go to IDLE.
  - On abort, PC, INSTRUCTION and IR_VALID=0 are unchanged, and any pending load is applied.
  - While FAULT=1, FETCH_REQ is ignored; PC_LOAD still works.
- Undefined: no counter, FAULT is constant 0, REQ waits indefinitely, and TIMEOUT_CYCLES is unused.

## Test plan
- Reset: hold RST=0 → PC=26'h0001000, INSTRUCTION=0, MEM_READ=0, IR_VALID=0. Release RST, pulse FETCH_REQ, MEM_READY=1 next cycle with MEM_DATA=32'h20220005 → INSTRUCTION=32'h20220005, PC=26'h0001001, IR_VALID=1, two cycles after the request.
- Wait states: FETCH_REQ, MEM_READY low for 3 cycles → MEM_ADDR stable at 26'h0001000 and MEM_READ=1 throughout. IR_VALID rises exactly one cycle after MEM_READY.
- Jump during fetch: PC_LOAD with PC_NEXT=26'h0002000 mid-REQ → after completion PC=26'h0002000, not PC+1. The next fetch drives MEM_ADDR=26'h0002000.
- Simultaneous load and request in IDLE: FETCH_REQ=1 with PC_LOAD=1, PC_NEXT=26'h0000040 → MEM_ADDR=26'h0000040. After completion PC=26'h0000041.
- Wrap and mid-fetch reset: load PC=26'h3FFFFFF, fetch → PC=0. Start a fetch, assert RST while BUSY=1 → MEM_READ=0 immediately, PC=26'h0001000.
- FETCH_TIMEOUT_EN build: never assert MEM_READY → FAULT=1 and MEM_READ=0 after 15 wait cycles. A subsequent FETCH_REQ keeps MEM_READ=0. RST clears FAULT.
